// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, jXX/cmovXX condition codes,
// status encodings and the condition-code register layout.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_CMOVXX = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // Status is carried as the low two bits of the architectural code.
    localparam logic [1:0] STAT_AOK = 2'd1;
    localparam logic [1:0] STAT_HLT = 2'd2;
    localparam logic [1:0] STAT_ADR = 2'd3;
    localparam logic [1:0] STAT_INS = 2'd0;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

endpackage

// File: rtl/y86_cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from the flag values.
// Shared with the decode-stage branch predictor.
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic       i_zf,
    input  logic       i_sf,
    input  logic       i_of,
    input  logic [3:0] i_ifun,
    output logic       o_cnd
);

    logic w_lt;
    assign w_lt = i_sf ^ i_of;

    always_comb begin
        // NOTE: default assigned first so every path drives o_cnd; no latch is inferred.
        o_cnd = 1'b0;
        case (i_ifun)
            C_YES:   o_cnd = 1'b1;
            C_LE:    o_cnd = w_lt | i_zf;
            C_L:     o_cnd = w_lt;
            C_E:     o_cnd = i_zf;
            C_NE:    o_cnd = ~i_zf;
            C_GE:    o_cnd = ~w_lt;
            C_G:     o_cnd = ~w_lt & ~i_zf;
            default: o_cnd = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_exec_cc.sv
// Execute-stage back half: condition-code register, cnd evaluation and the
// one-entry E->M output slot with a valid/ready handshake.
module y86_exec_cc
    import y86_pkg::*;
#(
    parameter int         WIDTH    = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_icode,
    input  logic [3:0]       in_ifun,
    input  logic [1:0]       in_stat,
    input  logic [WIDTH-1:0] in_alu,
    input  logic             in_alu_of,
    input  logic [3:0]       in_dste,
    input  logic             cc_freeze,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_icode,
    output logic [3:0]       out_ifun,
    output logic [1:0]       out_stat,
    output logic [WIDTH-1:0] out_vale,
    output logic [3:0]       out_dste,
    output logic             out_cnd,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    cc_t              r_cc;
    logic             r_valid;
    logic [3:0]       r_icode;
    logic [3:0]       r_ifun;
    logic [1:0]       r_stat;
    logic [WIDTH-1:0] r_vale;
    logic [3:0]       r_dste;
    logic             r_cnd;

    logic             w_accept;
    logic             w_cond;
    logic             w_cnd;
    logic [3:0]       w_dste;
    logic             w_cc_we;
    cc_t              w_cc_next;

    assign in_ready = ~r_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // cnd sees the flags as they stand before this cycle's OPq writes them.
    y86_cond_eval u_cond_eval (
        .i_zf   (r_cc.zf),
        .i_sf   (r_cc.sf),
        .i_of   (r_cc.of),
        .i_ifun (in_ifun),
        .o_cnd  (w_cond)
    );

    assign w_cnd  = (in_icode == ICODE_JXX || in_icode == ICODE_CMOVXX) ? w_cond : 1'b1;
    assign w_dste = (in_icode == ICODE_CMOVXX && !w_cnd) ? REG_NONE : in_dste;

    assign w_cc_we = w_accept && (in_icode == ICODE_OPQ) && (in_stat == STAT_AOK)
                     && !cc_freeze && !flush;
    assign w_cc_next = '{zf: (in_alu == '0), sf: in_alu[WIDTH-1], of: in_alu_of};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_cc    <= cc_t'(CC_RESET);
            r_valid <= 1'b0;
            r_icode <= '0;
            r_ifun  <= '0;
            r_stat  <= '0;
            r_vale  <= '0;
            r_dste  <= REG_NONE;
            r_cnd   <= 1'b0;
        end else begin
            if (w_cc_we) begin
                r_cc <= w_cc_next;
            end
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_icode <= in_icode;
                r_ifun  <= in_ifun;
                r_stat  <= in_stat;
                r_vale  <= in_alu;
                r_dste  <= w_dste;
                r_cnd   <= w_cnd;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_icode = r_icode;
    assign out_ifun  = r_ifun;
    assign out_stat  = r_stat;
    assign out_vale  = r_vale;
    assign out_dste  = r_dste;
    assign out_cnd   = r_cnd;
    assign cc_zf     = r_cc.zf;
    assign cc_sf     = r_cc.sf;
    assign cc_of     = r_cc.of;

endmodule

// File: tb/tb_y86_exec_cc.sv
// Scoreboard bench for y86_exec_cc: directed scenarios then random traffic,
// checked against a flag/condition reference model.
module tb_y86_exec_cc;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_icode;
    logic [3:0]   in_ifun;
    logic [1:0]   in_stat;
    logic [W-1:0] in_alu;
    logic         in_alu_of;
    logic [3:0]   in_dste;
    logic         cc_freeze;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_icode;
    logic [3:0]   out_ifun;
    logic [1:0]   out_stat;
    logic [W-1:0] out_vale;
    logic [3:0]   out_dste;
    logic         out_cnd;
    logic         cc_zf;
    logic         cc_sf;
    logic         cc_of;

    y86_exec_cc #(.WIDTH(W), .CC_RESET(3'b100)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_stat(in_stat),
        .in_alu(in_alu), .in_alu_of(in_alu_of), .in_dste(in_dste),
        .cc_freeze(cc_freeze), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_ifun(out_ifun), .out_stat(out_stat),
        .out_vale(out_vale), .out_dste(out_dste), .out_cnd(out_cnd),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   icode;
        logic [3:0]   ifun;
        logic [1:0]   stat;
        logic [W-1:0] vale;
        logic [3:0]   dste;
        logic         cnd;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: flag register {zf,sf,of} and whether the slot is occupied.
    logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
    logic m_full = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [3:0] fn, input logic zf, input logic sf,
                                      input logic of);
        logic less;
        less = (sf != of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    // Evaluated at the falling edge, where inputs and DUT outputs are settled.
    task automatic model_step();
        logic acc;
        exp_t e;
        check("cc", {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
        check("out_valid", out_valid, m_full);
        check("in_ready", in_ready, !m_full || out_ready);
        if (!rst_n) begin
            {m_zf, m_sf, m_of} = 3'b100;
            m_full = 1'b0;
            q.delete();
            return;
        end
        acc = in_valid && (!m_full || out_ready);
        if (flush) begin
            q.delete();
            m_full = 1'b0;
            return;
        end
        if (acc) begin
            e.icode = in_icode;
            e.ifun  = in_ifun;
            e.stat  = in_stat;
            e.vale  = in_alu;
            e.cnd   = (in_icode == 4'd7 || in_icode == 4'd2)
                      ? ref_cond(in_ifun, m_zf, m_sf, m_of) : 1'b1;
            e.dste  = (in_icode == 4'd2 && !e.cnd) ? 4'hF : in_dste;
            q.push_back(e);
            m_full = 1'b1;
            if (in_icode == 4'd6 && in_stat == 2'd1 && !cc_freeze) begin
                m_zf = (in_alu == 64'd0);
                m_sf = in_alu[63];
                m_of = in_alu_of;
            end
        end else if (out_ready) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: every completed output transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (q.size() == 0) begin
                check("unexpected_output", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_icode", out_icode, e.icode);
                check("out_ifun", out_ifun, e.ifun);
                check("out_stat", out_stat, e.stat);
                check("out_vale", out_vale, e.vale);
                check("out_dste", out_dste, e.dste);
                check("out_cnd", out_cnd, e.cnd);
            end
        end
    end

    task automatic cyc(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [1:0] st, input logic [63:0] alu, input logic of,
                       input logic [3:0] dst, input logic frz, input logic fl,
                       input logic ordy, input logic rn);
        in_valid  = v;
        in_icode  = ic;
        in_ifun   = fn;
        in_stat   = st;
        in_alu    = alu;
        in_alu_of = of;
        in_dste   = dst;
        cc_freeze = frz;
        flush     = fl;
        out_ready = ordy;
        rst_n     = rn;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 4'h1, 4'h0, 2'd1, 64'd0, 1'b0, 4'hF, 1'b0, 1'b0, ordy, 1'b1);
    endtask

    task automatic op(input logic [63:0] alu, input logic of);
        cyc(1'b1, 4'h6, 4'h0, 2'd1, alu, of, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        cyc(1'b0, 4'h0, 4'h0, 2'd0, 64'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 4'h0, 2'd0, 64'd0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_dste", out_dste, 4'hF);
        check("rst_vale", out_vale, 64'd0);
        check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

        // Signed overflow into the sign bit.
        op(64'h7FFF_FFFF_FFFF_FFFF + 64'd1, 1'b1);
        idle(1'b1);
        check("ovf_cc", {cc_zf, cc_sf, cc_of}, 3'b011);

        // Zero result then back-to-back je / jne.
        op(64'd0, 1'b0);
        cyc(1'b1, 4'h7, 4'h3, 2'd1, 64'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h7, 4'h4, 2'd1, 64'd0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);

        // cmovl not taken (SF=OF=0), then taken (SF=1).
        op(64'd5, 1'b0);
        cyc(1'b1, 4'h2, 4'h2, 2'd1, 64'd9, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
        op(64'h8000_0000_0000_0001, 1'b0);
        cyc(1'b1, 4'h2, 4'h2, 2'd1, 64'd9, 1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);

        // Downstream stall for three cycles with traffic waiting, then release.
        cyc(1'b1, 4'h6, 4'h0, 2'd1, 64'd0, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 4'h6, 4'h0, 2'd1, 64'hFFFF_0000_0000_0000, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stall_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        cyc(1'b1, 4'h6, 4'h0, 2'd1, 64'hFFFF_0000_0000_0000, 1'b1, 4'h4, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);

        // Freeze, non-AOK status and a flush coincident with accept leave CC alone.
        cyc(1'b1, 4'h6, 4'h0, 2'd1, 64'd0, 1'b0, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h6, 4'h0, 2'd3, 64'd0, 1'b0, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 4'h6, 4'h0, 2'd1, 64'd0, 1'b0, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1);
        check("flush_valid", out_valid, 1'b0);
        check("flush_cc", {cc_zf, cc_sf, cc_of}, 3'b011);

        // Reset with the slot full.
        cyc(1'b1, 4'h3, 4'h0, 2'd1, 64'd77, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 4'h3, 4'h0, 2'd1, 64'd78, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_dste", out_dste, 4'hF);
        check("mid_rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

        for (int i = 0; i < 3000; i++) begin
            logic [63:0] alu;
            logic [1:0]  st;
            int          mode;
            mode = int'($urandom_range(0, 4));
            alu  = {$urandom, $urandom};
            if (mode == 0) alu = 64'd0;
            else if (mode == 1) alu[63] = 1'b1;
            st = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            cyc($urandom_range(0, 4) != 0, 4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)),
                st, alu, 1'($urandom), 4'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 199) != 0);
        end

        for (int i = 0; i < 4; i++) idle(1'b1);
        check("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
